// File: rtl/temp_logger_if.sv
// Byte-stream and read-request signals between temp_logger and its neighbours.
// The master drives received bytes and pop requests; the slave (logger) returns popped records.
interface temp_logger_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_parity_err;
    logic        rd_req;
    logic        rd_valid;
    logic [7:0]  rd_temp;
    logic [16:0] rd_time;

    modport master (
        output rx_data, rx_valid, rx_parity_err, rd_req,
        input  rd_valid, rd_temp, rd_time
    );

    modport slave (
        input  rx_data, rx_valid, rx_parity_err, rd_req,
        output rd_valid, rd_temp, rd_time
    );
endinterface

// File: rtl/temp_logger.sv
// Timestamped temperature logger: circular record buffer with min/max/alarm tracking.
// Define TEMP_LOGGER_AVG_EN to add a 4-sample running average on avg_temp.
module temp_logger #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    temp_logger_if.slave      bus,
    input  logic [5:0]        seconds,
    input  logic [5:0]        minutes,
    input  logic [4:0]        hours,
    input  logic [7:0]        alarm_thresh,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic [7:0]        min_temp,
    output logic [7:0]        max_temp,
    output logic              alarm,
    output logic [CNT_W-1:0]  overrun_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [7:0]        avg_temp
);

    // Record layout: {hours, minutes, seconds, temperature}
    logic [24:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W:0]   count_q;
    logic              rd_valid_q;
    logic [7:0]        rd_temp_q;
    logic [16:0]       rd_time_q;
    logic [7:0]        min_q;
    logic [7:0]        max_q;
    logic              alarm_q;
    logic [CNT_W-1:0]  overrun_q;
    logic [CNT_W-1:0]  err_q;
    logic              wr;
    logic              rd;
    logic              bad;

    assign empty = (count_q == '0);
    assign full  = (count_q == (ADDR_W+1)'(DEPTH));
    assign wr    = bus.rx_valid & ~bus.rx_parity_err;
    assign bad   = bus.rx_valid & bus.rx_parity_err;
    assign rd    = bus.rd_req & ~empty;

    // Storage is not reset; only pointers define validity.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr_q] <= {hours, minutes, seconds, bus.rx_data};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_temp_q  <= '0;
            rd_time_q  <= '0;
            min_q      <= 8'hFF;
            max_q      <= 8'h00;
            alarm_q    <= 1'b0;
            overrun_q  <= '0;
            err_q      <= '0;
        end else begin
            rd_valid_q <= rd;
            if (rd) begin
                rd_temp_q <= mem[rd_ptr_q][7:0];
                rd_time_q <= mem[rd_ptr_q][24:8];
            end
            if (wr) begin
                wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            end
            // A write into a full buffer drops the oldest record.
            if (rd || (wr && full)) begin
                rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            end
            if (wr && !rd && !full) begin
                count_q <= count_q + (ADDR_W+1)'(1);
            end else if (rd && !wr) begin
                count_q <= count_q - (ADDR_W+1)'(1);
            end
            if (wr && full && !rd && (overrun_q != '1)) begin
                overrun_q <= overrun_q + CNT_W'(1);
            end
            if (bad && (err_q != '1)) begin
                err_q <= err_q + CNT_W'(1);
            end
            if (wr) begin
                if (bus.rx_data < min_q) min_q <= bus.rx_data;
                if (bus.rx_data > max_q) max_q <= bus.rx_data;
                alarm_q <= (bus.rx_data >= alarm_thresh);
            end
        end
    end

`ifdef TEMP_LOGGER_AVG_EN
    logic [7:0] samp_q [4];
    logic [7:0] avg_q;
    logic [9:0] sum;

    // Average over the new sample plus the three most recent stored ones.
    always_comb begin
        sum = 10'(bus.rx_data) + 10'(samp_q[0]) + 10'(samp_q[1]) + 10'(samp_q[2]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) samp_q[i] <= '0;
            avg_q <= '0;
        end else if (wr) begin
            samp_q[0] <= bus.rx_data;
            samp_q[1] <= samp_q[0];
            samp_q[2] <= samp_q[1];
            samp_q[3] <= samp_q[2];
            avg_q     <= sum[9:2];
        end
    end

    assign avg_temp = avg_q;
`else
    assign avg_temp = 8'h00;
`endif

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_temp  = rd_temp_q;
    assign bus.rd_time  = rd_time_q;
    assign count        = count_q;
    assign min_temp     = min_q;
    assign max_temp     = max_q;
    assign alarm        = alarm_q;
    assign overrun_cnt  = overrun_q;
    assign err_cnt      = err_q;

endmodule

// File: tb/tb_temp_logger.sv
// Directed bench for temp_logger: inputs change and outputs are sampled on the falling edge.
module tb_temp_logger;
`ifdef TEMP_LOGGER_AVG_EN
    localparam bit AvgOn = 1'b1;
`else
    localparam bit AvgOn = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [5:0] seconds;
    logic [5:0] minutes;
    logic [4:0] hours;
    logic [7:0] alarm_thresh;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic [7:0] min_temp;
    logic [7:0] max_temp;
    logic       alarm;
    logic [7:0] overrun_cnt;
    logic [7:0] err_cnt;
    logic [7:0] avg_temp;

    int vectors;
    int miscompares;

    temp_logger_if bus ();

    temp_logger dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus.slave),
        .seconds      (seconds),
        .minutes      (minutes),
        .hours        (hours),
        .alarm_thresh (alarm_thresh),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .min_temp     (min_temp),
        .max_temp     (max_temp),
        .alarm        (alarm),
        .overrun_cnt  (overrun_cnt),
        .err_cnt      (err_cnt),
        .avg_temp     (avg_temp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " count"},    32'(count), 32'd0);
        chk({tag, " empty"},    32'(empty), 32'd1);
        chk({tag, " full"},     32'(full), 32'd0);
        chk({tag, " min"},      32'(min_temp), 32'hFF);
        chk({tag, " max"},      32'(max_temp), 32'h00);
        chk({tag, " alarm"},    32'(alarm), 32'd0);
        chk({tag, " overrun"},  32'(overrun_cnt), 32'd0);
        chk({tag, " err"},      32'(err_cnt), 32'd0);
        chk({tag, " avg"},      32'(avg_temp), 32'd0);
        chk({tag, " rd_valid"}, 32'(bus.rd_valid), 32'd0);
        chk({tag, " rd_temp"},  32'(bus.rd_temp), 32'd0);
        chk({tag, " rd_time"},  32'(bus.rd_time), 32'd0);
    endtask

    // Called on a falling edge; returns on the next falling edge.
    task automatic wr_byte(input logic [7:0] d, input logic [4:0] h, input logic [5:0] m,
                           input logic [5:0] s, input logic perr, input logic req);
        bus.rx_data       = d;
        bus.rx_valid      = 1'b1;
        bus.rx_parity_err = perr;
        bus.rd_req        = req;
        hours             = h;
        minutes           = m;
        seconds           = s;
        @(negedge clk);
        bus.rx_valid      = 1'b0;
        bus.rx_parity_err = 1'b0;
        bus.rd_req        = 1'b0;
    endtask

    task automatic rd_pop(input string tag, input logic [7:0] et, input logic [16:0] etime);
        bus.rd_req = 1'b1;
        @(negedge clk);
        bus.rd_req = 1'b0;
        chk({tag, " rd_valid"}, 32'(bus.rd_valid), 32'd1);
        chk({tag, " rd_temp"},  32'(bus.rd_temp), 32'(et));
        chk({tag, " rd_time"},  32'(bus.rd_time), 32'(etime));
    endtask

    initial begin
        vectors           = 0;
        miscompares       = 0;
        reset             = 1'b0;
        bus.rx_data       = '0;
        bus.rx_valid      = 1'b0;
        bus.rx_parity_err = 1'b0;
        bus.rd_req        = 1'b0;
        seconds           = '0;
        minutes           = '0;
        hours             = '0;
        alarm_thresh      = 8'hFF;
        repeat (2) @(negedge clk);
        chk_reset_state("por");
        reset = 1'b1;
        @(negedge clk);

        // Basic: three timestamped writes then three pops
        wr_byte(8'h19, 5'd1, 6'd2, 6'd3, 1'b0, 1'b0);
        wr_byte(8'h1A, 5'd1, 6'd2, 6'd4, 1'b0, 1'b0);
        wr_byte(8'h1B, 5'd1, 6'd2, 6'd5, 1'b0, 1'b0);
        chk("basic count", 32'(count), 32'd3);
        chk("basic min", 32'(min_temp), 32'h19);
        chk("basic max", 32'(max_temp), 32'h1B);
        rd_pop("basic rd0", 8'h19, {5'd1, 6'd2, 6'd3});
        rd_pop("basic rd1", 8'h1A, {5'd1, 6'd2, 6'd4});
        rd_pop("basic rd2", 8'h1B, {5'd1, 6'd2, 6'd5});
        chk("basic count end", 32'(count), 32'd0);
        chk("basic empty end", 32'(empty), 32'd1);
        @(negedge clk);
        chk("rd_valid one-shot", 32'(bus.rd_valid), 32'd0);
        chk("rd_temp hold", 32'(bus.rd_temp), 32'h1B);

        // Read on empty is ignored
        bus.rd_req = 1'b1;
        @(negedge clk);
        bus.rd_req = 1'b0;
        chk("empty rd rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("empty rd count", 32'(count), 32'd0);

        // Write plus read while empty: write only, no bypass
        wr_byte(8'h77, 5'd3, 6'd4, 6'd5, 1'b0, 1'b1);
        chk("wr+rd empty rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("wr+rd empty count", 32'(count), 32'd1);
        rd_pop("wr+rd empty drain", 8'h77, {5'd3, 6'd4, 6'd5});

        // Overrun: 18 writes into a 16-deep buffer
        for (int i = 0; i < 18; i++) begin
            wr_byte(8'(i), 5'd0, 6'd0, 6'(i), 1'b0, 1'b0);
        end
        chk("ovr full", 32'(full), 32'd1);
        chk("ovr count", 32'(count), 32'd16);
        chk("ovr overrun_cnt", 32'(overrun_cnt), 32'd2);

        // Simultaneous write and read on a full buffer
        wr_byte(8'h55, 5'd2, 6'd3, 6'd4, 1'b0, 1'b1);
        chk("sim rd_valid", 32'(bus.rd_valid), 32'd1);
        chk("sim rd_temp", 32'(bus.rd_temp), 32'd2);
        chk("sim count", 32'(count), 32'd16);
        chk("sim overrun_cnt", 32'(overrun_cnt), 32'd2);
        for (int i = 3; i < 18; i++) begin
            rd_pop("ovr drain", 8'(i), 17'(i));
        end
        rd_pop("sim last", 8'h55, {5'd2, 6'd3, 6'd4});
        chk("ovr empty end", 32'(empty), 32'd1);
        chk("ovr min", 32'(min_temp), 32'h00);
        chk("ovr max", 32'(max_temp), 32'h77);

        // Parity error byte is dropped and counted
        wr_byte(8'hFF, 5'd0, 6'd0, 6'd0, 1'b1, 1'b0);
        chk("par count", 32'(count), 32'd0);
        chk("par err_cnt", 32'(err_cnt), 32'd1);
        chk("par max", 32'(max_temp), 32'h77);

        // Stats and alarm from a fresh reset
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("stats reset err_cnt", 32'(err_cnt), 32'd0);
        alarm_thresh = 8'h30;
        wr_byte(8'h20, 5'd0, 6'd0, 6'd1, 1'b0, 1'b0);
        chk("st0 alarm", 32'(alarm), 32'd0);
        chk("st0 avg", 32'(avg_temp), AvgOn ? 32'h08 : 32'h00);
        wr_byte(8'h40, 5'd0, 6'd0, 6'd2, 1'b0, 1'b0);
        chk("st1 alarm", 32'(alarm), 32'd1);
        chk("st1 max", 32'(max_temp), 32'h40);
        wr_byte(8'h10, 5'd0, 6'd0, 6'd3, 1'b0, 1'b0);
        chk("st2 alarm", 32'(alarm), 32'd0);
        chk("st2 min", 32'(min_temp), 32'h10);
        chk("st2 max", 32'(max_temp), 32'h40);
        chk("st2 avg", 32'(avg_temp), AvgOn ? 32'h1C : 32'h00);

        // Running average from reset
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        wr_byte(8'h10, 5'd0, 6'd0, 6'd0, 1'b0, 1'b0);
        chk("avg0", 32'(avg_temp), AvgOn ? 32'h04 : 32'h00);
        wr_byte(8'h20, 5'd0, 6'd0, 6'd0, 1'b0, 1'b0);
        chk("avg1", 32'(avg_temp), AvgOn ? 32'h0C : 32'h00);
        wr_byte(8'h30, 5'd0, 6'd0, 6'd0, 1'b0, 1'b0);
        chk("avg2", 32'(avg_temp), AvgOn ? 32'h18 : 32'h00);
        wr_byte(8'h40, 5'd0, 6'd0, 6'd0, 1'b0, 1'b0);
        chk("avg3", 32'(avg_temp), AvgOn ? 32'h28 : 32'h00);
        chk("avg count", 32'(count), 32'd4);

        // Async reset while a pop result is pending
        bus.rd_req = 1'b1;
        @(posedge clk);
        #2;
        chk("pre-reset rd_valid", 32'(bus.rd_valid), 32'd1);
        reset      = 1'b0;
        bus.rd_req = 1'b0;
        #1;
        chk_reset_state("mid");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post-reset rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("post-reset count", 32'(count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
